// File: rtl/core_decode_stage.sv
// RV32-style decode stage: combinational decode into a main/skid register pair, 1-cycle latency, IN_READY registered as "skid empty".
// Optional FP decode (FLW/FSW/FP-OP) enabled by defining CORE_DECODE_FPU_EN; otherwise those opcodes decode as ILLEGAL.
module core_decode_stage #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      IN_INST,
    input  logic [PC_W-1:0]  IN_PC,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [PC_W-1:0]  OUT_PC,
    output logic [4:0]       OUT_RD,
    output logic [4:0]       OUT_RS1,
    output logic [4:0]       OUT_RS2,
    output logic [31:0]      OUT_IMM,
    output logic [2:0]       OUT_FUNC3,
    output logic [6:0]       OUT_FUNC7,
    output logic [3:0]       OUT_OPCLASS,
    output logic             OUT_RDVALID,
    output logic             OUT_FRDVALID,
    output logic             OUT_ILLEGAL,
    output logic [CNT_W-1:0] DEC_COUNT
);
    localparam logic [3:0] CLS_ALUR = 4'd0,  CLS_ALUI = 4'd1,  CLS_BR    = 4'd2,  CLS_LOAD = 4'd3;
    localparam logic [3:0] CLS_ST   = 4'd4,  CLS_JAL  = 4'd5,  CLS_JALR  = 4'd6,  CLS_LUI  = 4'd7;
    localparam logic [3:0] CLS_AUI  = 4'd8,  CLS_FPOP = 4'd9,  CLS_FLW   = 4'd10, CLS_FSW  = 4'd11;
    localparam logic [3:0] CLS_IO   = 4'd12, CLS_FNC  = 4'd13, CLS_ROT   = 4'd14, CLS_ILL  = 4'd15;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [3:0]      opclass;
        logic            rdvalid;
        logic            frdvalid;
        logic            illegal;
    } dec_t;

    dec_t             dec, main_q, skid_q;
    logic             main_vld, skid_vld, in_rdy_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_fire, out_fire;
    logic             main_vld_n, skid_vld_n, ld_main_in, ld_main_skid, ld_skid;
    logic [6:0]       op;

    assign op = IN_INST[6:0];

    always_comb begin
        dec          = '0;
        dec.pc       = IN_PC;
        dec.rd       = IN_INST[11:7];
        dec.rs1      = IN_INST[19:15];
        dec.rs2      = IN_INST[24:20];
        dec.func3    = IN_INST[14:12];
        dec.func7    = IN_INST[31:25];
        dec.opclass  = CLS_ILL;

        case (op)
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111:
                dec.imm = {{20{IN_INST[31]}}, IN_INST[31:20]};
            7'b0100011:
                dec.imm = {{20{IN_INST[31]}}, IN_INST[31:25], IN_INST[11:7]};
            7'b1100011:
                dec.imm = {{19{IN_INST[31]}}, IN_INST[31], IN_INST[7], IN_INST[30:25], IN_INST[11:8], 1'b0};
            7'b1101111:
                dec.imm = {{11{IN_INST[31]}}, IN_INST[31], IN_INST[19:12], IN_INST[20], IN_INST[30:21], 1'b0};
`ifdef CORE_DECODE_FPU_EN
            7'b0000111:
                dec.imm = {{20{IN_INST[31]}}, IN_INST[31:20]};
            7'b0100111:
                dec.imm = {{20{IN_INST[31]}}, IN_INST[31:25], IN_INST[11:7]};
`endif
            default:
                dec.imm = (op[4:0] == 5'b10111) ? {IN_INST[31:12], 12'b0} : 32'h0;
        endcase

        case (op)
            7'b0110011: dec.opclass = CLS_ALUR;
            7'b0010011: dec.opclass = CLS_ALUI;
            7'b1100011: dec.opclass = CLS_BR;
            7'b0000011: dec.opclass = CLS_LOAD;
            7'b0100011: dec.opclass = CLS_ST;
            7'b1101111: dec.opclass = CLS_JAL;
            7'b1100111: dec.opclass = CLS_JALR;
            7'b0110111: dec.opclass = CLS_LUI;
            7'b0010111: dec.opclass = CLS_AUI;
            7'b0001011: dec.opclass = CLS_ROT;
            7'b0000001: if (IN_INST[14:13] == 2'b00) dec.opclass = CLS_IO;
            7'b0001111: if (IN_INST[14:13] == 2'b00) dec.opclass = CLS_FNC;
`ifdef CORE_DECODE_FPU_EN
            7'b0000111: begin dec.opclass = CLS_FLW; dec.frdvalid = 1'b1; end
            7'b0100111: dec.opclass = CLS_FSW;
            7'b1010011: begin
                case (IN_INST[31:25])
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b0001100,
                    7'b0010000, 7'b1111000, 7'b1101000, 7'b0101100: begin
                        dec.opclass  = CLS_FPOP;
                        dec.frdvalid = 1'b1;
                    end
                    7'b1100000: dec.opclass = CLS_FPOP;
                    // compares write an integer register and only exist for func3 0..2
                    7'b1010000: if (IN_INST[14:12] <= 3'b010) dec.opclass = CLS_FPOP;
                    default: ;
                endcase
            end
`endif
            default: ;
        endcase

        dec.illegal = (dec.opclass == CLS_ILL);
        case (dec.opclass)
            CLS_BR, CLS_ST, CLS_FSW, CLS_FNC, CLS_ILL: dec.rdvalid = 1'b0;
            default:                                   dec.rdvalid = !dec.frdvalid;
        endcase
    end

    assign in_fire  = IN_VALID && in_rdy_q;
    assign out_fire = main_vld && OUT_READY;

    always_comb begin
        main_vld_n   = main_vld;
        skid_vld_n   = skid_vld;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (out_fire) begin
            if (skid_vld) begin
                ld_main_skid = 1'b1;
                skid_vld_n   = 1'b0;
            end else if (in_fire) begin
                ld_main_in = 1'b1;
            end else begin
                main_vld_n = 1'b0;
            end
        end else if (in_fire) begin
            if (main_vld) begin
                ld_skid    = 1'b1;
                skid_vld_n = 1'b1;
            end else begin
                ld_main_in = 1'b1;
                main_vld_n = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            in_rdy_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            if (out_fire)
                cnt_q <= cnt_q + CNT_W'(1);
            if (FLUSH) begin
                main_vld <= 1'b0;
                skid_vld <= 1'b0;
                in_rdy_q <= 1'b1;
            end else begin
                main_vld <= main_vld_n;
                skid_vld <= skid_vld_n;
                in_rdy_q <= !skid_vld_n;
                if (ld_main_in)   main_q <= dec;
                if (ld_main_skid) main_q <= skid_q;
                if (ld_skid)      skid_q <= dec;
            end
        end
    end

    assign IN_READY     = in_rdy_q;
    assign OUT_VALID    = main_vld;
    assign OUT_PC       = main_q.pc;
    assign OUT_RD       = main_q.rd;
    assign OUT_RS1      = main_q.rs1;
    assign OUT_RS2      = main_q.rs2;
    assign OUT_IMM      = main_q.imm;
    assign OUT_FUNC3    = main_q.func3;
    assign OUT_FUNC7    = main_q.func7;
    assign OUT_OPCLASS  = main_q.opclass;
    assign OUT_RDVALID  = main_q.rdvalid;
    assign OUT_FRDVALID = main_q.frdvalid;
    assign OUT_ILLEGAL  = main_q.illegal;
    assign DEC_COUNT    = cnt_q;
endmodule

// File: tb/tb_core_decode_stage.sv
// Bench for core_decode_stage: table of decode vectors streamed through a scoreboard plus flush/reset/backpressure sequences.
module tb_core_decode_stage;
    localparam int CNT_W = 4;
`ifdef CORE_DECODE_FPU_EN
    localparam bit FPU = 1'b1;
`else
    localparam bit FPU = 1'b0;
`endif

    logic        CLK = 1'b0, RST_N = 1'b0, FLUSH = 1'b0;
    logic        IN_VALID = 1'b0, IN_READY, OUT_VALID, OUT_READY = 1'b0;
    logic [31:0] IN_INST = '0, IN_PC = '0, OUT_PC, OUT_IMM;
    logic [4:0]  OUT_RD, OUT_RS1, OUT_RS2;
    logic [2:0]  OUT_FUNC3;
    logic [6:0]  OUT_FUNC7;
    logic [3:0]  OUT_OPCLASS;
    logic        OUT_RDVALID, OUT_FRDVALID, OUT_ILLEGAL;
    logic [CNT_W-1:0] DEC_COUNT;

    core_decode_stage #(.PC_W(32), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INST(IN_INST), .IN_PC(IN_PC),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_PC(OUT_PC),
        .OUT_RD(OUT_RD), .OUT_RS1(OUT_RS1), .OUT_RS2(OUT_RS2),
        .OUT_IMM(OUT_IMM), .OUT_FUNC3(OUT_FUNC3), .OUT_FUNC7(OUT_FUNC7),
        .OUT_OPCLASS(OUT_OPCLASS), .OUT_RDVALID(OUT_RDVALID),
        .OUT_FRDVALID(OUT_FRDVALID), .OUT_ILLEGAL(OUT_ILLEGAL), .DEC_COUNT(DEC_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] inst;
        logic [3:0]  cls;
        logic [31:0] imm;
        logic        rdv;
        logic        frdv;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [3:0]  cls;
        logic        rdv, frdv, ill;
    } exp_t;

    int               checks = 0, errors = 0;
    exp_t             sb[$];
    exp_t             exp_cur;
    logic [CNT_W-1:0] cnt_exp = '0;
    vec_t             vt[$];
    bit               acc;

    task automatic chk(string name, logic [127:0] act, logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic vec_t vf(logic [31:0] inst, logic [3:0] cls, logic rdv, logic frdv);
        vec_t v;
        if (FPU) v = '{inst, cls, 32'h0, rdv, frdv};
        else     v = '{inst, 4'd15, 32'h0, 1'b0, 1'b0};
        return v;
    endfunction

    task automatic drive(vec_t v, logic [31:0] pc);
        IN_INST  = v.inst;
        IN_PC    = pc;
        IN_VALID = 1'b1;
        exp_cur  = '{pc: pc, rd: v.inst[11:7], rs1: v.inst[19:15], rs2: v.inst[24:20],
                     imm: v.imm, f3: v.inst[14:12], f7: v.inst[31:25], cls: v.cls,
                     rdv: v.rdv, frdv: v.frdv, ill: (v.cls == 4'd15)};
    endtask

    // One clock: score the outgoing word, model the edge, then check the counter.
    task automatic step(output bit in_acc);
        bit   out_acc;
        exp_t act, e;
        in_acc  = IN_VALID && IN_READY;
        out_acc = OUT_VALID && OUT_READY;
        if (out_acc) begin
            act = '{pc: OUT_PC, rd: OUT_RD, rs1: OUT_RS1, rs2: OUT_RS2, imm: OUT_IMM,
                    f3: OUT_FUNC3, f7: OUT_FUNC7, cls: OUT_OPCLASS, rdv: OUT_RDVALID,
                    frdv: OUT_FRDVALID, ill: OUT_ILLEGAL};
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got pc %h expected no output", OUT_PC);
            end else begin
                e = sb.pop_front();
                chk("out_record", 128'(act), 128'(e));
            end
        end
        @(posedge CLK);
        if (!RST_N) begin
            sb.delete();
            cnt_exp = '0;
            in_acc  = 1'b0;
        end else begin
            if (out_acc) cnt_exp++;
            if (FLUSH) begin
                sb.delete();
                in_acc = 1'b0;
            end else if (in_acc) begin
                sb.push_back(exp_cur);
            end
        end
        @(negedge CLK);
        chk("dec_count", 128'(DEC_COUNT), 128'(cnt_exp));
    endtask

    task automatic send(vec_t v, logic [31:0] pc);
        bit a;
        int n = 0;
        drive(v, pc);
        do begin
            step(a);
            n++;
            if (!a) OUT_READY = 1'b1;
        end while (!a && n < 20);
        if (!a) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no acceptance expected acceptance within 20 cycles");
        end
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bit a;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        while ((sb.size() > 0 || OUT_VALID) && n < 50) begin
            step(a);
            n++;
        end
        chk("drain_empty", 128'(sb.size()), 128'(0));
        chk("drain_out_valid", 128'(OUT_VALID), 128'(0));
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_out_valid"}, 128'(OUT_VALID), 128'(0));
        chk({tag, "_in_ready"}, 128'(IN_READY), 128'(1));
        chk({tag, "_count"}, 128'(DEC_COUNT), 128'(0));
        chk({tag, "_imm"}, 128'(OUT_IMM), 128'(0));
        chk({tag, "_opclass"}, 128'(OUT_OPCLASS), 128'(0));
        chk({tag, "_flags"}, 128'({OUT_RDVALID, OUT_FRDVALID, OUT_ILLEGAL}), 128'(0));
    endtask

    task automatic do_reset();
        bit a;
        RST_N = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        step(a);
        RST_N = 1'b1;
    endtask

    initial begin
        vec_t addi, beq, fadd;
        logic [CNT_W-1:0] base;
        addi = '{32'h00510093, 4'd1, 32'h00000005, 1'b1, 1'b0};
        beq  = '{32'hFE000EE3, 4'd2, 32'hFFFFFFFC, 1'b0, 1'b0};
        fadd = vf(32'h003100D3, 4'd9, 1'b0, 1'b1);
        vt.push_back(addi);
        vt.push_back(beq);
        vt.push_back(fadd);
        vt.push_back('{32'h002081B3, 4'd0,  32'h00000000, 1'b1, 1'b0});
        vt.push_back('{32'hFF812283, 4'd3,  32'hFFFFFFF8, 1'b1, 1'b0});
        vt.push_back('{32'h00512623, 4'd4,  32'h0000000C, 1'b0, 1'b0});
        vt.push_back('{32'h008000EF, 4'd5,  32'h00000008, 1'b1, 1'b0});
        vt.push_back('{32'h00008067, 4'd6,  32'h00000000, 1'b1, 1'b0});
        vt.push_back('{32'h12345137, 4'd7,  32'h12345000, 1'b1, 1'b0});
        vt.push_back('{32'hFFFFF197, 4'd8,  32'hFFFFF000, 1'b1, 1'b0});
        vt.push_back('{32'h00001201, 4'd12, 32'h00000000, 1'b1, 1'b0});
        vt.push_back('{32'h00002201, 4'd15, 32'h00000000, 1'b0, 1'b0});
        vt.push_back('{32'h0FF0000F, 4'd13, 32'h000000FF, 1'b0, 1'b0});
        vt.push_back('{32'h0000200F, 4'd15, 32'h00000000, 1'b0, 1'b0});
        vt.push_back('{32'h0020818B, 4'd14, 32'h00000000, 1'b1, 1'b0});
        vt.push_back('{32'hFFFFFFFF, 4'd15, 32'h00000000, 1'b0, 1'b0});
        vt.push_back(vf(32'h00012087, 4'd10, 1'b0, 1'b1));
        vt.push_back(vf(32'h00312027, 4'd11, 1'b0, 1'b0));
        vt.push_back(vf(32'hC00100D3, 4'd9,  1'b1, 1'b0));
        vt.push_back(vf(32'hA03120D3, 4'd9,  1'b1, 1'b0));
        vt.push_back(vf(32'hA03130D3, 4'd15, 1'b0, 1'b0));
        vt.push_back(vf(32'h023100D3, 4'd15, 1'b0, 1'b0));
        vt.push_back(vf(32'hF00100D3, 4'd9,  1'b0, 1'b1));

        @(negedge CLK);
        do_reset();
        check_reset_state("reset");

        // single instructions into an idle stage: valid one cycle after acceptance
        send(addi, 32'h100);
        chk("addi_latency_valid", 128'(OUT_VALID), 128'(1));
        drain();
        send(beq, 32'h104);
        chk("beq_latency_valid", 128'(OUT_VALID), 128'(1));
        drain();
        send(fadd, 32'h108);
        drain();

        // full table streamed with irregular backpressure
        for (int i = 0; i < vt.size(); i++) begin
            OUT_READY = (i % 3 != 2);
            send(vt[i], 32'h1000 + 32'(i) * 4);
        end
        drain();

        // backpressure: third instruction blocked, then in-order release
        OUT_READY = 1'b0;
        send(addi, 32'h200);
        send(beq, 32'h204);
        drive(vt[3], 32'h208);
        step(acc);
        chk("third_blocked", 128'(acc), 128'(0));
        chk("skid_full_in_ready", 128'(IN_READY), 128'(0));
        base = DEC_COUNT;
        OUT_READY = 1'b1;
        step(acc);
        step(acc);
        chk("count_after_two", 128'(DEC_COUNT), 128'(base + CNT_W'(2)));
        IN_VALID = 1'b0;
        drain();

        // flush with both registers full
        OUT_READY = 1'b0;
        send(addi, 32'h300);
        send(beq, 32'h304);
        base = DEC_COUNT;
        FLUSH = 1'b1;
        step(acc);
        FLUSH = 1'b0;
        chk("flush_out_valid", 128'(OUT_VALID), 128'(0));
        chk("flush_in_ready", 128'(IN_READY), 128'(1));
        chk("flush_count_same", 128'(DEC_COUNT), 128'(base));

        // flush overrides a same-cycle input, but the same-cycle delivery still counts
        send(addi, 32'h310);
        base = DEC_COUNT;
        drive(beq, 32'h314);
        OUT_READY = 1'b1;
        FLUSH = 1'b1;
        step(acc);
        FLUSH = 1'b0;
        IN_VALID = 1'b0;
        chk("flush_in_dropped", 128'(OUT_VALID), 128'(0));
        chk("flush_out_counted", 128'(DEC_COUNT), 128'(base + CNT_W'(1)));
        drain();

        // counter wrap: 17 deliveries on a 4-bit counter
        do_reset();
        OUT_READY = 1'b1;
        for (int i = 0; i < 17; i++) send(addi, 32'h400 + 32'(i) * 4);
        drain();
        chk("wrap_count", 128'(DEC_COUNT), 128'(1));

        // reset mid-stream discards everything in flight
        OUT_READY = 1'b0;
        send(beq, 32'h500);
        send(vt[4], 32'h504);
        drive(addi, 32'h508);
        RST_N = 1'b0;
        step(acc);
        RST_N = 1'b1;
        IN_VALID = 1'b0;
        check_reset_state("midreset");
        send(vt[8], 32'h600);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected completion by 200000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/core_decode_stage.md
CORE_DECODE_STAGE -- requirements
Module: core_decode_stage

Interface
REQ-001 SHALL have parameter PC_W, default 32, giving the program-counter width.
REQ-002 SHALL have parameter CNT_W, default 16, giving the decoded-instruction counter width.
REQ-003 SHALL have port CLK, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port FLUSH, input, 1 bit: discard all held instructions.
REQ-006 SHALL have ports IN_VALID (input, 1), IN_READY (output, 1), IN_INST (input, 32), IN_PC (input, PC_W): upstream fetch handshake.
REQ-007 SHALL have ports OUT_VALID (output, 1), OUT_READY (input, 1), OUT_PC (output, PC_W): downstream handshake.
REQ-008 SHALL have ports OUT_RD, OUT_RS1, OUT_RS2 (output, 5 each): INST[11:7], INST[19:15], INST[24:20].
REQ-009 SHALL have ports OUT_IMM (output, 32), OUT_FUNC3 (output, 3), OUT_FUNC7 (output, 7).
REQ-010 SHALL have port OUT_OPCLASS (output, 4): 0 ALU-R, 1 ALU-I, 2 BRANCH, 3 LOAD, 4 STORE, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 FP-OP, 10 FLW, 11 FSW, 12 IO, 13 FENCE, 14 ROT, 15 ILLEGAL.
REQ-011 SHALL have ports OUT_RDVALID, OUT_FRDVALID, OUT_ILLEGAL (output, 1 each).
REQ-012 SHALL have port DEC_COUNT (output, CNT_W): count of instructions delivered downstream.

Function
REQ-013 Stage SHALL hold a main register and one skid register, each with its own valid bit.
REQ-014 IN_READY SHALL be a registered signal, equal to "skid register empty".
REQ-015 An input transfer SHALL occur when IN_VALID && IN_READY; an output transfer SHALL occur when OUT_VALID && OUT_READY.
REQ-016 Decode SHALL be combinational on IN_INST, with results captured at the transfer edge. Latency is 1 cycle from input transfer to OUT_VALID when the main register is empty.
REQ-017 When an input transfer occurs while the main register is full and no output transfer occurs, the decoded word SHALL go to the skid register.
REQ-018 An output transfer while the skid register is full SHALL move skid to main in the same edge and free the skid register.
REQ-019 Simultaneous input transfer and output transfer with the skid register empty SHALL load the main register directly.
REQ-020 Outputs SHALL remain stable while OUT_VALID && !OUT_READY. No instruction SHALL be dropped or duplicated.
REQ-021 Immediate by opcode:
- I-type (1100111, 0000011, 0010011, 0000111, 0001111): sign-extended INST[31:20].
- S-type (0100011, 0100111): sign-extended store immediate.
- B-type (1100011): sign-extended branch immediate, bit0 = 0.
- U-type (INST[4:0] = 10111): INST[31:12] followed by 12 zeros.
- J-type (1101111): sign-extended jump immediate, bit0 = 0.
- All others: 0.
REQ-022 Opcode mapping: ALU-R 0110011; ALU-I 0010011; IO 0000001 with func3 000/001; ROT 0001011; FENCE 0001111 with func3 000/001.
REQ-023 FP-OP SHALL be opcode 1010011 with func7 in {0000000, 0000100, 0001000, 0001100, 0010000, 1010000 (func3 000/001/010), 1111000, 1101000, 1100000, 0101100}.
REQ-024 Any other encoding, or a listed opcode with an unlisted func3/func7, SHALL give OPCLASS 15 and OUT_ILLEGAL = 1.
REQ-025 OUT_FRDVALID SHALL be 1 for FLW and for FP-OP with func7 in {0000000, 0000100, 0001000, 0001100, 0010000, 1111000, 1101000, 0101100}.
REQ-026 OUT_RDVALID SHALL be 0 for BRANCH, STORE, FSW, FENCE, ILLEGAL and every OUT_FRDVALID case; otherwise 1.
REQ-027 DEC_COUNT SHALL increment by 1 on each output transfer, wrap at 2^CNT_W, and not count flushed entries.
REQ-028 FLUSH SHALL clear both valid bits and set IN_READY = 1 at the next edge, overriding a same-cycle input transfer. An output transfer in that cycle still counts.

Reset
REQ-029 With RST_N = 0 at an edge: both valid bits, OUT_VALID, DEC_COUNT, OUT_IMM, OUT_OPCLASS, and all flag outputs SHALL be 0; IN_READY SHALL be 1.
REQ-030 Reset SHALL take priority over FLUSH and over any transfer. An instruction in flight at reset SHALL be discarded.

Configuration
REQ-031 Macro CORE_DECODE_FPU_EN defined: FLW, FSW and FP-OP SHALL decode per REQ-021 to REQ-025.
REQ-032 Macro CORE_DECODE_FPU_EN undefined: opcodes 0000111, 0100111 and 1010011 SHALL decode as ILLEGAL, OUT_FRDVALID SHALL be constant 0, and no FP decode logic SHALL be present.

Verification
REQ-033 Send 0x00510093 (addi x1,x2,5) into an idle stage -> next cycle: OUT_VALID = 1, OPCLASS 1, IMM 0x00000005, RD 1, RS1 2, RDVALID 1.
REQ-034 Send 0xFE000EE3 (beq x0,x0,-4) -> OPCLASS 2, IMM 0xFFFFFFFC, RDVALID 0.
REQ-035 Send 0x003100D3 (fadd.s f1,f2,f3): FPU_EN set -> OPCLASS 9, FRDVALID 1, RDVALID 0. FPU_EN clear -> OPCLASS 15, ILLEGAL 1.
REQ-036 Hold OUT_READY = 0, send 3 instructions -> 2 accepted, IN_READY = 0. Then release OUT_READY -> in-order delivery, DEC_COUNT = 2.
REQ-037 Assert FLUSH with both registers full -> next cycle OUT_VALID = 0, IN_READY = 1, DEC_COUNT unchanged.
REQ-038 CNT_W = 4 and 17 deliveries -> DEC_COUNT = 1. Assert RST_N = 0 mid-stream -> all outputs 0 and IN_READY = 1 next cycle.
